// File: rtl/autoseq_pkg.sv
// Shared types and defaults for the reset sequencer and its auto-input channels.
package autoseq_pkg;

  localparam int DEF_NCH         = 3;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_HOLD_CYCLES = 4095;
  localparam int DEF_DB_CYCLES   = 16;

  // Top-level phase: HOLD keeps the system in reset, RUN lets the channels play out.
  typedef enum logic {
    TOP_HOLD = 1'b0,
    TOP_RUN  = 1'b1
  } top_state_t;

  // Per-channel schedule phase.
  typedef enum logic [2:0] {
    CH_IDLE  = 3'd0,
    CH_WAIT  = 3'd1,
    CH_PULSE = 3'd2,
    CH_GAP   = 3'd3,
    CH_DONE  = 3'd4
  } chan_state_t;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/autoseq_chan.sv
// One auto-input channel: waits, then emits one or more active-low pulses,
// then parks in DONE until the top returns to HOLD.
module autoseq_chan
  import autoseq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             sysclk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] period,
  output logic             auto_n,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  chan_state_t      state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic [CNT_W-1:0] delay_q, width_q, period_q;
  logic [CNT_W-1:0] gap_len;

  // A period no longer than the pulse still leaves one high cycle between pulses.
  assign gap_len = (period_q > width_q) ? (period_q - width_q) : ONE;

  // Next-state logic; counters compare for equality against length-1 so no value wraps.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_next = state;
    cnt_clr    = 1'b0;
    case (state)
      CH_IDLE: begin
        if (start) begin
          state_next = en ? CH_WAIT : CH_DONE;
          cnt_clr    = 1'b1;
        end
      end
      CH_WAIT: begin
        if ((delay_q == '0) || (cnt == delay_q - ONE)) begin
          state_next = (width_q == '0) ? CH_DONE : CH_PULSE;
          cnt_clr    = 1'b1;
        end
      end
      CH_PULSE: begin
        if (cnt == width_q - ONE) begin
          state_next = (period_q == '0) ? CH_DONE : CH_GAP;
          cnt_clr    = 1'b1;
        end
      end
      CH_GAP: begin
        if (cnt == gap_len - ONE) begin
          state_next = CH_PULSE;
          cnt_clr    = 1'b1;
        end
      end
      CH_DONE: state_next = CH_DONE;
      default: begin
        state_next = CH_IDLE;
        cnt_clr    = 1'b1;
      end
    endcase
    if (clear) begin
      state_next = CH_IDLE;
      cnt_clr    = 1'b1;
    end
  end

  // State register with outputs registered from the next state, so they track it with no lag.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= CH_IDLE;
      auto_n <= 1'b1;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      auto_n <= (state_next != CH_PULSE);
      done   <= (state_next == CH_DONE);
    end
  end

  // Phase counter: runs only in timed phases and is cleared on every phase change.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (state inside {CH_WAIT, CH_PULSE, CH_GAP}) begin
      cnt <= cnt + ONE;
    end
  end

  // Schedule snapshot taken at RUN entry; later changes on the inputs are ignored.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      delay_q  <= '0;
      width_q  <= '0;
      period_q <= '0;
    end else if (start) begin
      delay_q  <= delay;
      width_q  <= width;
      period_q <= period;
    end
  end

endmodule

// File: rtl/reset_autoseq.sv
// Reset stretcher with button debounce and NCH scheduled auto-input pulse generators.
module reset_autoseq
  import autoseq_pkg::*;
#(
  parameter int NCH         = DEF_NCH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int DB_CYCLES   = DEF_DB_CYCLES
) (
  input  logic               sysclk,
  input  logic               reset_n,
  input  logic               button,
  input  logic [NCH-1:0]     cfg_en,
  input  logic [NCH*CNT_W-1:0] cfg_delay,
  input  logic [NCH*CNT_W-1:0] cfg_width,
  input  logic [NCH*CNT_W-1:0] cfg_period,
  output logic               reset,
  output logic [NCH-1:0]     auto_n,
  output logic [NCH-1:0]     done
);

  localparam int DB_W   = cnt_width(DB_CYCLES);
  localparam int HOLD_W = cnt_width(HOLD_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic              sync_1, sync_2, db;
  logic [DB_W-1:0]   db_cnt;
  top_state_t        state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic              start, clear;

  // Two-flop synchroniser followed by a debouncer that needs DB_CYCLES stable samples to flip.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      db     <= 1'b0;
      db_cnt <= '0;
    end else begin
      // NOTE: non-blocking so sync_2 takes the old sync_1, giving a true two-stage chain.
      sync_1 <= button;
      sync_2 <= sync_1;
      if (sync_2 != db) begin
        if (db_cnt == DB_LAST) begin
          db     <= sync_2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Top phase: any reset cause restarts the hold count; HOLD_CYCLES quiet cycles release RUN.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    if (state == TOP_HOLD) begin
      if (db) begin
        hold_next = '0;
      end else if (hold_cnt == HOLD_LAST) begin
        state_next = TOP_RUN;
        hold_next  = '0;
      end else begin
        hold_next = hold_cnt + HOLD_W'(1);
      end
    end else if (db) begin
      state_next = TOP_HOLD;
      hold_next  = '0;
    end
  end

  assign start = (state == TOP_HOLD) && (state_next == TOP_RUN);
  assign clear = (state_next == TOP_HOLD);

  // Top state, hold counter and the registered reset output.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= TOP_HOLD;
      hold_cnt <= '0;
      reset    <= 1'b1;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
      reset    <= (state_next == TOP_HOLD);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    autoseq_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .sysclk  (sysclk),
      .reset_n (reset_n),
      .start   (start),
      .clear   (clear),
      .en      (cfg_en[i]),
      .delay   (cfg_delay[i*CNT_W +: CNT_W]),
      .width   (cfg_width[i*CNT_W +: CNT_W]),
      .period  (cfg_period[i*CNT_W +: CNT_W]),
      .auto_n  (auto_n[i]),
      .done    (done[i])
    );
  end

endmodule

// File: tb/tb_reset_autoseq.sv
// Self-checking bench for reset_autoseq: constant vectors, hand sequences and a random run
// compared every cycle against a schedule model computed from cycle numbers.
module tb_reset_autoseq;

  localparam int NCH   = 3;
  localparam int CNT_W = 6;
  localparam int HOLD  = 8;
  localparam int DB    = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic                 sysclk;
  logic                 reset_n;
  logic                 button;
  logic [NCH-1:0]       cfg_en;
  logic [NCH*CNT_W-1:0] cfg_delay, cfg_width, cfg_period;
  logic                 reset;
  logic [NCH-1:0]       auto_n, done;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  reset_autoseq #(
    .NCH(NCH), .CNT_W(CNT_W), .HOLD_CYCLES(HOLD), .DB_CYCLES(DB)
  ) dut (
    .sysclk     (sysclk),
    .reset_n    (reset_n),
    .button     (button),
    .cfg_en     (cfg_en),
    .cfg_delay  (cfg_delay),
    .cfg_width  (cfg_width),
    .cfg_period (cfg_period),
    .reset      (reset),
    .auto_n     (auto_n),
    .done       (done)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Button samples wait two edges before the debouncer sees them; the schedule of a
  // channel is a pure function of the latched config and the cycle number n after RUN
  // entry (n=1 is the first cycle with reset low).
  bit hist[$];
  bit m_db, m_run;
  int m_diff, m_quiet, m_n;
  bit m_en [NCH];
  int m_d [NCH], m_w [NCH], m_p [NCH];

  function automatic logic [1:0] chan_exp(input bit en, input int d, input int w,
                                          input int p, input int n);
    int de, p0, gap, span;
    if (!en) return 2'b11;                      // {auto_n, done}
    de = (d == 0) ? 1 : d;
    if (w == 0) return (n > de) ? 2'b11 : 2'b10;
    p0 = de + 1;
    if (n < p0) return 2'b10;
    if (p == 0) return (n < p0 + w) ? 2'b00 : 2'b11;
    gap  = (p > w) ? p - w : 1;
    span = w + gap;
    return (((n - p0) % span) < w) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [2*NCH:0] model_out();
    logic [NCH-1:0] an, dn;
    logic [1:0] r;
    an = '1;
    dn = '0;
    if (m_run) begin
      for (int i = 0; i < NCH; i++) begin
        r = chan_exp(m_en[i], m_d[i], m_w[i], m_p[i], m_n);
        an[i] = r[1];
        dn[i] = r[0];
      end
    end
    return {!m_run, an, dn};
  endfunction

  task automatic model_reset();
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
    m_db = 0; m_run = 0; m_diff = 0; m_quiet = 0; m_n = 0;
  endtask

  task automatic model_step();
    bit seen;
    seen = hist.pop_front();
    hist.push_back(button);
    if (m_db) begin
      m_run = 0;
      m_quiet = 0;
    end else if (!m_run) begin
      m_quiet++;
      if (m_quiet == HOLD) begin
        m_run = 1;
        m_n = 1;
        m_quiet = 0;
        for (int i = 0; i < NCH; i++) begin
          m_en[i] = cfg_en[i];
          m_d[i]  = int'(cfg_delay[i*CNT_W +: CNT_W]);
          m_w[i]  = int'(cfg_width[i*CNT_W +: CNT_W]);
          m_p[i]  = int'(cfg_period[i*CNT_W +: CNT_W]);
        end
      end
    end else begin
      m_n++;
    end
    if (seen != m_db) begin
      m_diff++;
      if (m_diff == DB) begin
        m_db = seen;
        m_diff = 0;
      end
    end else begin
      m_diff = 0;
    end
  endtask

  always @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  always @(negedge sysclk) begin
    if (chk_on) check("model", 32'({reset, auto_n, done}), 32'(model_out()));
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_cfg(input int ch, input bit en, input int d, input int w, input int p);
    cfg_en[ch] = en;
    cfg_delay[ch*CNT_W +: CNT_W]  = CNT_W'(d);
    cfg_width[ch*CNT_W +: CNT_W]  = CNT_W'(w);
    cfg_period[ch*CNT_W +: CNT_W] = CNT_W'(p);
  endtask

  function automatic int rv();
    if ($urandom_range(0, 5) == 0) return int'($urandom_range(0, CMAX));
    return int'($urandom_range(0, 8));
  endfunction

  task automatic rand_cfg();
    for (int i = 0; i < NCH; i++) set_cfg(i, $urandom_range(0, 4) != 0, rv(), rv(), rv());
  endtask

  // Pulse reset_n away from the clock edges; returns just before edge 1 after release.
  task automatic do_por();
    @(negedge sysclk); #2 reset_n = 1'b0;
    @(negedge sysclk); #2 reset_n = 1'b1;
  endtask

  typedef struct {
    bit en;
    int d, w, p, n;
    bit exp_auto_n, exp_done;
  } vec_t;
  vec_t vecs[$];

  initial begin : watchdog
    #5000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    reset_n = 1'b1;
    button  = 1'b0;
    cfg_en = '0; cfg_delay = '0; cfg_width = '0; cfg_period = '0;
    #1 reset_n = 1'b0;
    #1 check("rst_async", 32'({reset, auto_n, done}), 32'({1'b1, 3'b111, 3'b000}));
    do_por();
    chk_on = 1;

    // Channel 0 schedule vectors: {en, delay, width, period, n, auto_n, done}.
    vecs.push_back('{1, 5, 3, 0, 5, 1, 0});
    vecs.push_back('{1, 5, 3, 0, 6, 0, 0});
    vecs.push_back('{1, 5, 3, 0, 8, 0, 0});
    vecs.push_back('{1, 5, 3, 0, 9, 1, 1});
    vecs.push_back('{1, 0, 2, 10, 1, 1, 0});
    vecs.push_back('{1, 0, 2, 10, 2, 0, 0});
    vecs.push_back('{1, 0, 2, 10, 3, 0, 0});
    vecs.push_back('{1, 0, 2, 10, 4, 1, 0});
    vecs.push_back('{1, 0, 2, 10, 11, 1, 0});
    vecs.push_back('{1, 0, 2, 10, 12, 0, 0});
    vecs.push_back('{1, 0, 2, 10, 13, 0, 0});
    vecs.push_back('{1, 0, 2, 10, 14, 1, 0});
    vecs.push_back('{1, 0, 2, 10, 42, 0, 0});
    vecs.push_back('{1, 3, 0, 5, 3, 1, 0});
    vecs.push_back('{1, 3, 0, 5, 4, 1, 1});
    vecs.push_back('{1, 0, 4, 2, 5, 0, 0});
    vecs.push_back('{1, 0, 4, 2, 6, 1, 0});
    vecs.push_back('{1, 0, 4, 2, 7, 0, 0});
    vecs.push_back('{1, 0, 4, 2, 11, 1, 0});
    vecs.push_back('{0, 5, 3, 0, 1, 1, 1});
    vecs.push_back('{1, 63, 63, 0, 63, 1, 0});
    vecs.push_back('{1, 63, 63, 0, 64, 0, 0});
    vecs.push_back('{1, 63, 63, 0, 126, 0, 0});
    vecs.push_back('{1, 63, 63, 0, 127, 1, 1});
    vecs.push_back('{1, 1, 3, 3, 4, 0, 0});
    vecs.push_back('{1, 1, 3, 3, 5, 1, 0});
    vecs.push_back('{1, 1, 3, 3, 6, 0, 0});
    vecs.push_back('{1, 2, 1, 0, 3, 0, 0});
    vecs.push_back('{1, 2, 1, 0, 4, 1, 1});

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      set_cfg(0, v.en, v.d, v.w, v.p);
      set_cfg(1, 0, 0, 0, 0);
      set_cfg(2, 0, 0, 0, 0);
      do_por();
      repeat (HOLD) @(posedge sysclk);
      repeat (v.n - 1) @(posedge sysclk);
      @(negedge sysclk);
      check($sformatf("vec%0d", i), 32'({auto_n[0], done[0]}), 32'({v.exp_auto_n, v.exp_done}));
    end

    // Power-on: reset stays high for exactly HOLD cycles after reset_n release.
    do_por();
    check("por_k0", 32'(reset), 32'(1));
    for (int k = 1; k <= HOLD; k++) begin
      @(posedge sysclk); @(negedge sysclk);
      check($sformatf("por_k%0d", k), 32'(reset), 32'(k < HOLD));
    end

    // Button glitch shorter than the debounce window is ignored.
    repeat (3) @(negedge sysclk);
    button = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge sysclk); @(negedge sysclk);
      check($sformatf("glitch_e%0d", e), 32'(reset), 32'(0));
      button = (e + 1 <= 3);
    end
    // A 6-cycle press: rises after sync+debounce, falls HOLD cycles after debounced release.
    button = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      @(posedge sysclk); @(negedge sysclk);
      check($sformatf("press_e%0d", e), 32'(reset), 32'((e >= 7) && (e <= 19)));
      button = (e + 1 <= 6);
    end

    // Mid-run press during a pulse, then restart with a new config latched.
    set_cfg(0, 1, 2, 20, 0);
    set_cfg(1, 0, 0, 0, 0);
    set_cfg(2, 1, 0, 1, 3);
    do_por();
    repeat (HOLD) @(posedge sysclk);
    repeat (4) @(posedge sysclk);
    @(negedge sysclk);
    button = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge sysclk); @(negedge sysclk);
      check($sformatf("midrun_e%0d", e), 32'({reset, auto_n[0], done[1]}),
            32'((e < 7) ? 3'b001 : 3'b110));
      button = (e + 1 <= 6);
    end
    set_cfg(0, 1, 1, 2, 0);
    set_cfg(1, 1, 0, 1, 0);
    for (int e = 8; e <= 20; e++) begin
      @(posedge sysclk); @(negedge sysclk);
      check($sformatf("midhold_e%0d", e), 32'(reset), 32'(e < 20));
    end
    for (int n = 1; n <= 4; n++) begin
      if (n > 1) begin
        @(posedge sysclk); @(negedge sysclk);
      end
      check($sformatf("restart_n%0d", n), 32'({auto_n[0], done[0]}),
            32'((n == 1) ? 2'b10 : (n < 4) ? 2'b00 : 2'b11));
    end

    // Random configs, restarts, mid-run config changes and button noise.
    for (int it = 0; it < 40; it++) begin
      rand_cfg();
      if ($urandom_range(0, 1) == 0) begin
        do_por();
      end else begin
        @(negedge sysclk);
        button = 1'b1;
        repeat ($urandom_range(5, 9)) @(negedge sysclk);
        button = 1'b0;
      end
      repeat ($urandom_range(20, 150)) begin
        @(negedge sysclk);
        if ($urandom_range(0, 15) == 0) rand_cfg();
        if ($urandom_range(0, 24) == 0) button = ~button;
      end
      button = 1'b0;
    end

    repeat (4) @(negedge sysclk);
    chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_autoseq.md
RESET_AUTOSEQ -- requirements
Module: reset_autoseq

Interface
REQ-001 SHALL have parameter NCH, default 3, number of auto-input channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 32, width of the delay, width and period counters.
REQ-003 SHALL have parameter HOLD_CYCLES, default 4095, reset stretch length in sysclk cycles (>=1).
REQ-004 SHALL have parameter DB_CYCLES, default 16, button debounce stability length (>=1).
REQ-005 SHALL have port sysclk, input, 1, the only clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port button, input, 1, asynchronous active-high manual reset request.
REQ-008 SHALL have port cfg_en, input, NCH, per-channel enable.
REQ-009 SHALL have ports cfg_delay, cfg_width and cfg_period, input, NCH*CNT_W each, per-channel schedule; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-010 SHALL have port reset, output, 1, active-high stretched system reset.
REQ-011 SHALL have port auto_n, output, NCH, active-low generated input pulses.
REQ-012 SHALL have port done, output, NCH, channel schedule complete.

Function
REQ-013 SHALL synchronise button through two flops, then debounce it: the debounced value changes only after the synchronised value has differed from it for DB_CYCLES consecutive cycles.
REQ-014 SHALL treat "reset cause" as debounced button high.
REQ-015 SHALL hold reset high while a reset cause is present, then for exactly HOLD_CYCLES further cycles, then drive it low.
REQ-016 SHALL restart the hold count from zero on any reset cause, including mid-hold and during RUN.
REQ-017 SHALL have a top FSM with two states: HOLD (reset=1) and RUN (reset=0); HOLD->RUN when the hold count reaches HOLD_CYCLES; RUN->HOLD on a reset cause.
REQ-018 SHALL latch cfg_en, cfg_delay, cfg_width and cfg_period on the HOLD->RUN transition; changes during RUN SHALL be ignored.
REQ-019 SHALL run each channel through the FSM IDLE, WAIT, PULSE, GAP, DONE; all channels SHALL be IDLE while in HOLD.
REQ-020 SHALL take channel transitions as follows:
  - IDLE->WAIT on RUN entry if enabled.
  - IDLE->DONE on RUN entry if disabled.
  - WAIT lasts cfg_delay cycles; a value of 0 goes to PULSE on the next cycle.
  - WAIT->DONE instead if cfg_width==0.
REQ-021 SHALL drive auto_n[i] low in PULSE and only in PULSE; PULSE SHALL last exactly cfg_width cycles.
REQ-022 SHALL take the PULSE exit by period:
  - PULSE->DONE if cfg_period==0 (one-shot).
  - Otherwise PULSE->GAP, with GAP lasting cfg_period-cfg_width cycles, and then GAP->PULSE.
  - If cfg_period<=cfg_width, GAP SHALL last exactly 1 cycle.
REQ-023 SHALL make the pulse-start-to-pulse-start spacing exactly cfg_period cycles when cfg_period>cfg_width.
REQ-024 SHALL drive done[i] high only in DONE; DONE is terminal until HOLD.
REQ-025 SHALL use counters that compare for equality and never wrap; the maximum values (2^CNT_W-1) SHALL be valid and exact.
REQ-026 SHALL, on RUN->HOLD mid-pulse, drive auto_n[i] high and clear done in the same cycle reset rises.
REQ-027 SHALL register all outputs; there is no combinational path from inputs to outputs.

Reset
REQ-028 SHALL, while reset_n is low, asynchronously force:
  - reset=1, auto_n=all ones, done=0;
  - FSMs to HOLD/IDLE, counters to 0;
  - synchroniser and debounced value to 0.
REQ-029 SHALL count the hold from reset_n deassertion, so reset falls HOLD_CYCLES cycles after that deassertion with button low.

Structure
REQ-030 SHALL define the top and channel state encodings and the default parameter constants in the shared package autoseq_pkg.
REQ-031 SHALL implement one channel in sub-module autoseq_chan, instantiated NCH times by a generate loop; the top holds the sync, debounce, hold counter and top FSM.

Verification
REQ-032 SHALL cover power-on: HOLD_CYCLES=8, button=0, release reset_n -> reset high for exactly 8 cycles, falls on cycle 8.
REQ-033 SHALL cover button glitch: DB_CYCLES=4, a 3-cycle button pulse -> no reset; a 6-cycle pulse -> reset rises, and falls HOLD_CYCLES cycles after the debounced release.
REQ-034 SHALL cover one-shot: delay=5, width=3, period=0 -> auto_n low on cycles 6-8 after RUN entry, then done=1.
REQ-035 SHALL cover periodic: delay=0, width=2, period=10 -> auto_n low 2 cycles every 10 cycles indefinitely, done=0.
REQ-036 SHALL cover edge configs: width=0 -> no pulse and done after delay; period=2 with width=4 -> 4 low, 1 high, repeating; disabled channel -> done on RUN entry.
REQ-037 SHALL cover mid-run reset: a button press during PULSE -> auto_n high the cycle reset rises, done cleared, schedule restarts after the hold with newly latched config.
